ram_upload: RTL and testbench
=============================

Name: ram_upload

Overview:
- Readback counterpart of the BIOS download path: streams a word-wide memory region out as bytes to the IO controller's upload channel (ioctl upload).
- Fetches 16-bit words from the system side over a level-request/pulse-acknowledge port into a 64-word ping-pong buffer, split into two 32-word halves.
- Presents bytes low-byte-first, matching the download packing where even byte address = low byte.
- Sits between data_io's upload side and the system's memory port.

Parameters:
- ADDR_W, 13, width of mem_addr (word address).
- BASE_ADDR, 0, first word address fetched.
- TOTAL_WORDS, 8192, words per session; must be a non-zero multiple of 32 (elaboration-time check).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  upload session active (level).
- ioctl_rd  in  1  one-cycle strobe: the current byte has been consumed; advance.
- ioctl_din  out  8  current byte.
- ready  out  1  ioctl_din holds a valid byte.
- done  out  1  all bytes of the session consumed.
- underrun  out  1  sticky: ioctl_rd arrived while ready=0.
- mem_req  out  1  word request (level).
- mem_addr  out  ADDR_W  word address of the pending request.
- mem_ack  in  1  one-cycle pulse; mem_dout is valid in this cycle.
- mem_dout  in  16  returned word.

Behaviour:
- Reset values: mem_req=0, mem_addr=BASE_ADDR, ioctl_din=0, ready=0, done=0, underrun=0. Both half_full flags clear; fill/drain half pointers=0; counters=0.
- Session start: rising edge of ioctl_upload (registered-delayed compare) clears counters, flags, done and underrun, and sets mem_addr=BASE_ADDR. Fill starts the next cycle.
- Fill FSM states: F_IDLE, F_REQ, F_HOLD, F_DRAIN_ACK.
  - F_IDLE -> F_REQ on session start; mem_req=1.
  - In F_REQ, each mem_ack writes mem_dout to buf[fh*32 + widx] and increments widx (5-bit), mem_addr and the fetched-word count.
  - mem_ack while mem_req=0 is ignored.
  - When widx wraps (32nd word of a half), set half_full[fh] and toggle fh.
    - Fetched count = TOTAL_WORDS: go to F_IDLE, mem_req=0.
    - Else new fh half full: go to F_HOLD, mem_req=0 in the next cycle.
    - Otherwise stay in F_REQ with mem_req=1 held.
  - F_HOLD -> F_REQ when half_full[fh] clears.
  - mem_addr does not wrap explicitly; it is ADDR_W bits wide and wraps modulo 2^ADDR_W.
- Drain:
  - Byte pointer bidx is 6 bits per half; dh is the drain half.
  - ready = session active & half_full[dh] & read pipeline settled.
  - ioctl_din = bidx[0] ? buf_word[15:8] : buf_word[7:0], where buf_word = buf[dh*32 + bidx[5:1]] via a registered read.
  - ioctl_din becomes valid 2 cycles after half_full[dh] sets, or 2 cycles after an accepted ioctl_rd. ready is low during those 2 cycles.
  - Callers space ioctl_rd at least 3 cycles apart.
  - ioctl_rd with ready=1 increments bidx. On wrap (64th byte), clear half_full[dh] and toggle dh.
  - ioctl_rd with ready=0: set underrun, do not advance; ioctl_din is unchanged.
- Simultaneous events:
  - Fill setting half_full[fh] and drain clearing half_full[dh] in the same cycle act on different halves; both take effect.
  - The same half is never set and cleared in one cycle by construction.
- done: set in the cycle after the final byte (2*TOTAL_WORDS bytes) is consumed; ready=0 thereafter. Held until the session ends or reset.
- Session end (falling edge of ioctl_upload), including mid-transfer:
  - ready=0 immediately.
  - If a request is outstanding in F_REQ, mem_req stays 1 until the next mem_ack (word discarded), via F_DRAIN_ACK -> F_IDLE, so the system-side handshake completes cleanly.
  - Otherwise go to F_IDLE at once.
- reset overrides everything in any state, including a pending request: mem_req drops next cycle. The system side must tolerate an unacknowledged request being withdrawn by reset.

Decomposition:
- Shared package: fill FSM state enum, half size constant (32 words), byte-per-half constant (64).
- Sub-module upload_dpram: 64x16 simple dual-port RAM, one write port (fill), one registered read port (drain). Everything else stays in ram_upload.

Test Plan:
- TOTAL_WORDS=32, words 0x1100+i returned one cycle after each req: bytes read out are 0x00,0x11,0x01,0x11,...,0x1F,0x11; done=1 after the 64th ioctl_rd; mem_addr=32 at end.
- TOTAL_WORDS=128 with no ioctl_rd: exactly 64 acks accepted, mem_req=0 with both halves full; 64 ioctl_rd restart fill at mem_addr=64.
- ioctl_rd issued immediately after session start (before the first half fills): underrun=1, ioctl_din=0, byte pointer unchanged; the first good byte after fill equals the low byte of word 0.
- ioctl_upload dropped while mem_req=1 and the ack is 5 cycles late: mem_req stays high until the ack, the word is not written, and fill returns to idle. A new session refetches from BASE_ADDR.
- reset asserted mid-transfer at word 40: all outputs take reset values next cycle. A subsequent session streams from word 0 correctly.
- mem_ack pulsed while mem_req=0: ignored; fetched count and mem_addr unchanged.

Source files
------------

// File: rtl/ram_upload_pkg.sv
// Shared types and sizing for the ram_upload readback path.
package ram_upload_pkg;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_HOLD, F_DRAIN_ACK} fill_state_t;
  localparam int HALF_WORDS = 32;
  localparam int HALF_BYTES = 64;
endpackage

// File: rtl/upload_dpram.sv
// 64x16 simple dual-port RAM: one write port for the fill side, one read port
// for the drain side. The read data is registered, so it is valid one cycle after the address.
module upload_dpram (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [5:0]  raddr,
  output logic [15:0] rdata
);
  logic [15:0] mem [0:63];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ram_upload.sv
// Streams a word-wide memory region out as bytes (low byte first) to the ioctl upload channel,
// through a two-half ping-pong buffer filled over a level-req / pulse-ack memory port.
module ram_upload
  import ram_upload_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int BASE_ADDR   = 0,
  parameter int TOTAL_WORDS = 8192
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ready,
  output logic              done,
  output logic              underrun,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_dout
);
  localparam int FW = $clog2(TOTAL_WORDS + 1);
  localparam int BW = $clog2(2 * TOTAL_WORDS + 1);
  localparam logic [4:0] LAST_WIDX = 5'(HALF_WORDS - 1);
  localparam logic [5:0] LAST_BIDX = 6'(HALF_BYTES - 1);

  if (TOTAL_WORDS == 0 || (TOTAL_WORDS % HALF_WORDS) != 0) begin : g_bad_total
    $error("ram_upload: TOTAL_WORDS must be a non-zero multiple of 32");
  end

  fill_state_t   fstate;
  logic          upload_q;
  logic          start;
  logic [4:0]    widx;
  logic          fh;
  logic [1:0]    half_full;
  logic [FW-1:0] fetched;
  logic [FW-1:0] fetched_inc;
  logic          dh;
  logic [5:0]    bidx;
  logic [BW-1:0] nbytes;
  logic [BW-1:0] nbytes_inc;
  logic          rd_settle;
  logic          rdy_q;
  logic [15:0]   rdata;
  logic          wr;
  logic          set_half;
  logic          accept;
  logic          clr_half;

  assign start       = ioctl_upload & ~upload_q;
  assign fetched_inc = fetched + 1'b1;
  assign nbytes_inc  = nbytes + 1'b1;
  assign wr          = (fstate == F_REQ) & mem_req & mem_ack & ioctl_upload & ~start;
  assign set_half    = wr & (widx == LAST_WIDX);
  assign ready       = rdy_q & ioctl_upload;
  assign accept      = ioctl_rd & ready;
  assign clr_half    = accept & (bidx == LAST_BIDX);

  upload_dpram u_dpram (
    .clk   (clk_sys),
    .we    (wr),
    .waddr ({fh, widx}),
    .wdata (mem_dout),
    .raddr ({dh, bidx[5:1]}),
    .rdata (rdata)
  );

  // Fill side: fetch words into half fh, stall when the next half is still being drained.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      upload_q <= 1'b0;
      fstate   <= F_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= ADDR_W'(BASE_ADDR);
      widx     <= '0;
      fh       <= 1'b0;
      fetched  <= '0;
    end else begin
      upload_q <= ioctl_upload;
      if (start) begin
        widx     <= '0;
        fh       <= 1'b0;
        fetched  <= '0;
        mem_addr <= ADDR_W'(BASE_ADDR);
        // An old request still waiting for its ack must complete before refetching.
        if (fstate != F_DRAIN_ACK || mem_ack) begin
          fstate  <= F_REQ;
          mem_req <= 1'b1;
        end
      end else begin
        case (fstate)
          F_IDLE: mem_req <= 1'b0;
          F_REQ: begin
            if (!ioctl_upload) begin
              if (mem_ack) begin
                fstate  <= F_IDLE;
                mem_req <= 1'b0;
              end else begin
                fstate <= F_DRAIN_ACK;
              end
            end else if (mem_ack) begin
              widx     <= widx + 1'b1;
              mem_addr <= mem_addr + 1'b1;
              fetched  <= fetched_inc;
              if (widx == LAST_WIDX) begin
                fh <= ~fh;
                if (fetched_inc == FW'(TOTAL_WORDS)) begin
                  fstate  <= F_IDLE;
                  mem_req <= 1'b0;
                end else if (half_full[~fh]) begin
                  fstate  <= F_HOLD;
                  mem_req <= 1'b0;
                end
              end
            end
          end
          F_HOLD: begin
            if (!ioctl_upload) begin
              fstate <= F_IDLE;
            end else if (!half_full[fh]) begin
              fstate  <= F_REQ;
              mem_req <= 1'b1;
            end
          end
          F_DRAIN_ACK: begin
            if (mem_ack) begin
              fstate  <= ioctl_upload ? F_REQ : F_IDLE;
              mem_req <= ioctl_upload;
            end
          end
          default: begin
            fstate  <= F_IDLE;
            mem_req <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset || start) begin
      half_full <= '0;
    end else begin
      if (set_half) half_full[fh] <= 1'b1;
      if (clr_half) half_full[dh] <= 1'b0;
    end
  end

  // Drain side: rd_settle marks rdata matching {dh,bidx}; rdy_q marks ioctl_din loaded from it.
  always_ff @(posedge clk_sys) begin
    if (reset || start) begin
      dh        <= 1'b0;
      bidx      <= '0;
      nbytes    <= '0;
      done      <= 1'b0;
      underrun  <= 1'b0;
      ioctl_din <= '0;
      rd_settle <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      rd_settle <= ioctl_upload & half_full[dh] & ~accept & ~done;
      rdy_q     <= ioctl_upload & rd_settle & ~accept & ~done;
      if (rd_settle && !accept) ioctl_din <= bidx[0] ? rdata[15:8] : rdata[7:0];
      if (ioctl_rd && !ready) underrun <= 1'b1;
      if (accept) begin
        bidx   <= bidx + 1'b1;
        nbytes <= nbytes_inc;
        if (bidx == LAST_BIDX) dh <= ~dh;
        if (nbytes_inc == BW'(2 * TOTAL_WORDS)) done <= 1'b1;
      end
      if (!ioctl_upload) done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ram_upload.sv
// Directed bench: two instances (32-word and 128-word sessions) behind a word memory model
// that returns 0x1100+addr; expected bytes are queued at stimulus time and popped per ioctl_rd.
module tb_ram_upload;
  logic clk = 1'b0;
  logic reset, upload, rd, en, poke;
  int   lat;

  logic [7:0]  din_a, din_b;
  logic        ready_a, ready_b, done_a, done_b, underrun_a, underrun_b;
  logic        req_a, req_b;
  logic [12:0] addr_a, addr_b;
  logic        ack_a = 1'b0, ack_b = 1'b0;
  logic [15:0] dout_a = '0, dout_b = '0;
  logic        ack_in_a, ack_in_b;
  int          wt_a = 0, wt_b = 0;
  int          ackcnt_b = 0;

  int total = 0;
  int bad = 0;
  logic [7:0] sbq [$];

  assign ack_in_a = ack_a | poke;
  assign ack_in_b = ack_b | poke;

  always #5 clk = ~clk;

  ram_upload #(.ADDR_W(13), .BASE_ADDR(0), .TOTAL_WORDS(32)) dut_a (
    .clk_sys(clk), .reset(reset), .ioctl_upload(upload), .ioctl_rd(rd),
    .ioctl_din(din_a), .ready(ready_a), .done(done_a), .underrun(underrun_a),
    .mem_req(req_a), .mem_addr(addr_a), .mem_ack(ack_in_a), .mem_dout(dout_a));

  ram_upload #(.ADDR_W(13), .BASE_ADDR(0), .TOTAL_WORDS(128)) dut_b (
    .clk_sys(clk), .reset(reset), .ioctl_upload(upload), .ioctl_rd(rd),
    .ioctl_din(din_b), .ready(ready_b), .done(done_b), .underrun(underrun_b),
    .mem_req(req_b), .mem_addr(addr_b), .mem_ack(ack_in_b), .mem_dout(dout_b));

  // Memory model: ack one cycle wide, `lat` falling edges after the request is seen.
  always begin
    @(negedge clk);
    if (ack_a) ack_a = 1'b0;
    else if (req_a && en) begin
      if (wt_a >= lat) begin ack_a = 1'b1; dout_a = 16'h1100 + 16'(addr_a); wt_a = 0; end
      else wt_a++;
    end else wt_a = 0;
  end

  always begin
    @(negedge clk);
    if (ack_b) ack_b = 1'b0;
    else if (req_b && en) begin
      if (wt_b >= lat) begin ack_b = 1'b1; dout_b = 16'h1100 + 16'(addr_b); wt_b = 0; end
      else wt_b++;
    end else wt_b = 0;
  end

  always @(posedge clk) if (ack_in_b && req_b) ackcnt_b++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int first, input int n);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = 16'h1100 + 16'(first + i);
      sbq.push_back(w[7:0]);
      sbq.push_back(w[15:8]);
    end
  endtask

  task automatic drain(input bit sel, input int n, input string tag);
    int t;
    logic [7:0] exp;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!(sel ? ready_b : ready_a) && t < 400) begin @(negedge clk); t++; end
      if (t >= 400) begin
        check({tag, "_ready_wait"}, 32'(sel ? ready_b : ready_a), 1);
        return;
      end
      exp = (sbq.size() > 0) ? sbq.pop_front() : 8'hxx;
      check(tag, 32'(sel ? din_b : din_a), 32'(exp));
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
  endtask

  task automatic check_reset(input bit sel, input string tag);
    check({tag, "_req"}, 32'(sel ? req_b : req_a), 0);
    check({tag, "_addr"}, 32'(sel ? addr_b : addr_a), 0);
    check({tag, "_din"}, 32'(sel ? din_b : din_a), 0);
    check({tag, "_flags"}, sel ? {29'd0, ready_b, done_b, underrun_b}
                               : {29'd0, ready_a, done_a, underrun_a}, 0);
  endtask

  initial begin
    int t;
    int ackbase;
    reset = 1'b1; upload = 1'b0; rd = 1'b0; en = 1'b1; poke = 1'b0; lat = 0;
    repeat (4) @(negedge clk);
    check_reset(0, "rst_a");
    check_reset(1, "rst_b");
    reset = 1'b0;
    @(negedge clk);

    // 32-word session streamed end to end
    push_words(0, 32);
    upload = 1'b1;
    drain(0, 64, "t1_byte");
    check("t1_done", 32'(done_a), 1);
    check("t1_ready", 32'(ready_a), 0);
    check("t1_addr", 32'(addr_a), 32);
    check("t1_req", 32'(req_a), 0);
    check("t1_underrun", 32'(underrun_a), 0);
    @(negedge clk);
    check("t1_ready_hold", 32'(ready_a), 0);
    upload = 1'b0;
    repeat (6) @(negedge clk);

    // stray ack with no request outstanding
    en = 1'b0;
    repeat (2) @(negedge clk);
    poke = 1'b1;
    @(negedge clk);
    poke = 1'b0;
    @(negedge clk);
    check("t6_addr", 32'(addr_a), 32);
    check("t6_req", 32'(req_a), 0);

    // ioctl_rd before any data: underrun, no advance
    upload = 1'b1;
    @(negedge clk);
    check("t3_req", 32'(req_a), 1);
    check("t3_addr", 32'(addr_a), 0);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("t3_underrun", 32'(underrun_a), 1);
    check("t3_din", 32'(din_a), 0);
    check("t3_ready", 32'(ready_a), 0);
    push_words(0, 32);
    en = 1'b1;
    drain(0, 64, "t3_byte");
    check("t3_done", 32'(done_a), 1);
    check("t3_underrun_sticky", 32'(underrun_a), 1);
    upload = 1'b0;
    repeat (6) @(negedge clk);

    // 128-word session, no reader: both halves fill then fill stalls
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    ackbase = ackcnt_b;
    upload = 1'b1;
    repeat (300) @(negedge clk);
    check("t2_acks", 32'(ackcnt_b - ackbase), 64);
    check("t2_req", 32'(req_b), 0);
    check("t2_addr", 32'(addr_b), 64);
    check("t2_ready", 32'(ready_b), 1);
    push_words(0, 32);
    drain(1, 64, "t2_byte");
    @(negedge clk);
    check("t2_refill_req", 32'(req_b), 1);
    check("t2_refill_addr", 32'(addr_b), 64);
    upload = 1'b0;
    repeat (10) @(negedge clk);

    // session dropped with a late ack outstanding
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    lat = 5;
    upload = 1'b1;
    @(negedge clk);
    ackbase = ackcnt_b;
    upload = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_req_held", 32'(req_b), 1);
    t = 0;
    while (req_b && t < 30) begin @(negedge clk); t++; end
    check("t4_req_drop", 32'(req_b), 0);
    check("t4_acks", 32'(ackcnt_b - ackbase), 1);
    check("t4_addr", 32'(addr_b), 0);
    lat = 0;
    repeat (3) @(negedge clk);
    upload = 1'b1;
    @(negedge clk);
    check("t4_restart_addr", 32'(addr_b), 0);
    push_words(0, 32);
    drain(1, 64, "t4_byte");
    upload = 1'b0;
    repeat (10) @(negedge clk);

    // reset in the middle of a fill
    upload = 1'b1;
    t = 0;
    while (addr_b != 13'd40 && t < 400) begin @(negedge clk); t++; end
    check("t5_reach40", 32'(addr_b), 40);
    reset = 1'b1;
    upload = 1'b0;
    @(negedge clk);
    check_reset(1, "t5_rst");
    reset = 1'b0;
    @(negedge clk);
    upload = 1'b1;
    push_words(0, 32);
    drain(1, 64, "t5_byte");
    upload = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
